wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 31 +++
 rtl/wb_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - bus bundle between two Wishbone masters, the arbiter and the MIO slave bus
interface wb_arbiter_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_stb_o, s_ack_i;
  logic [1:0]  grant;

  // Arbiter side: the masters see it as their slave.
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_we_o, s_stb_o, grant,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_we_o, s_stb_o, grant,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master Wishbone arbiter onto the MIO bus; define WB_ARB_TIMEOUT_EN for the ack timeout
module wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_gnt;
  logic   w_req0, w_req1, w_stb, w_timeout;

  assign w_req0 = bus.m0_cyc_i & bus.m0_stb_i;
  assign w_req1 = bus.m1_cyc_i & bus.m1_stb_i;
  assign w_stb  = ((r_state == GNT0) & bus.m0_stb_i) | ((r_state == GNT1) & bus.m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_cnt;

  // Ack in the final cycle suppresses the timeout.
  assign w_timeout = (r_cnt == LP_LAST) & w_stb & ~bus.s_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (r_state == IDLE || bus.s_ack_i || w_next != r_state) begin
      r_cnt <= 8'd0;
    end else if (w_stb) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  // Timeout disabled: never fires for any legal TIMEOUT_CYCLES.
  assign w_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0) r_last_gnt <= 1'b0;
      else if (w_next == GNT1) r_last_gnt <= 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.s_adr_o  = 32'd0;
    bus.s_dat_o  = 32'd0;
    bus.s_we_o   = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m0_dat_o = bus.s_dat_i;
    bus.m1_dat_o = bus.s_dat_i;
    bus.grant    = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next = r_last_gnt ? GNT0 : GNT1;
        else if (w_req0)      w_next = GNT0;
        else if (w_req1)      w_next = GNT1;
      end
      GNT0: begin
        bus.grant    = 2'b01;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_stb_o  = bus.m0_stb_i;
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_err_o = w_timeout;
        // Hand straight to the waiting master so no idle cycle is lost.
        if (!bus.m0_cyc_i || w_timeout) w_next = w_req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        bus.grant    = 2'b10;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_stb_o  = bus.m1_stb_i;
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_err_o = w_timeout;
        if (!bus.m1_cyc_i || w_timeout) w_next = w_req0 ? GNT0 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
